// File: rtl/wts_key_scheduler_pkg.sv
// Shared constants and key command encoding for the envelope key scheduler.
// Optional status output is enabled with WTS_KEY_SCHEDULER_STATUS_EN.
package wts_key_scheduler_pkg;

    localparam int         NUM_CH   = 5;
    localparam logic [2:0] SLOT_NOP = 3'd5;

    typedef enum logic [1:0] {
        KEY_NONE    = 2'd0,
        KEY_ON      = 2'd1,
        KEY_RELEASE = 2'd2,
        KEY_OFF     = 2'd3
    } key_cmd_t;

    // Slot order is 0..4 for channels A..E, then the no-op slot, then back to 0.
    function automatic logic [2:0] next_slot(input logic [2:0] s);
        return (s >= SLOT_NOP) ? 3'd0 : s + 3'd1;
    endfunction

endpackage

// File: rtl/wts_key_pending_slot.sv
// One-entry pending key command store for a single envelope channel.
// With WTS_KEY_SCHEDULER_STATUS_EN it also tracks whether the key is held.
module wts_key_pending_slot
    import wts_key_scheduler_pkg::*;
(
    input  logic     clk,
    input  logic     nreset,
    input  logic     wr_en,
    input  key_cmd_t wr_cmd,
    input  logic     dispatch,
    output logic     pending,
    output logic     key_on,
    output logic     key_release,
    output logic     key_off
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
    ,
    output logic     key_status
`endif
);

    key_cmd_t cmd;

    // The top only raises wr_en while the entry is empty, and dispatch only
    // acts on a full entry, so the two never collide on the same edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pending     <= 1'b0;
            cmd         <= KEY_NONE;
            key_on      <= 1'b0;
            key_release <= 1'b0;
            key_off     <= 1'b0;
        end else begin
            key_on      <= 1'b0;
            key_release <= 1'b0;
            key_off     <= 1'b0;
            if (dispatch && pending) begin
                pending <= 1'b0;
                case (cmd)
                    KEY_ON:      key_on      <= 1'b1;
                    KEY_RELEASE: key_release <= 1'b1;
                    KEY_OFF:     key_off     <= 1'b1;
                    default: ;
                endcase
            end
            if (wr_en) begin
                pending <= 1'b1;
                cmd     <= wr_cmd;
            end
        end
    end

`ifdef WTS_KEY_SCHEDULER_STATUS_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            key_status <= 1'b0;
        end else if (dispatch && pending) begin
            if (cmd == KEY_ON) begin
                key_status <= 1'b1;
            end else if (cmd == KEY_OFF) begin
                key_status <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/wts_key_scheduler.sv
// Time-slot sequencer and key command scheduler for the 5-channel envelope generator.
// Define WTS_KEY_SCHEDULER_STATUS_EN to add the key_status[4:0] output.
module wts_key_scheduler
    import wts_key_scheduler_pkg::*;
#(
    parameter int SLOT_DIV = 1
)
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_ch,
    input  logic [1:0] cmd_key,
    output logic [2:0] active,
    output logic       frame_start,
    output logic       ch_a_key_on,
    output logic       ch_a_key_release,
    output logic       ch_a_key_off,
    output logic       ch_b_key_on,
    output logic       ch_b_key_release,
    output logic       ch_b_key_off,
    output logic       ch_c_key_on,
    output logic       ch_c_key_release,
    output logic       ch_c_key_off,
    output logic       ch_d_key_on,
    output logic       ch_d_key_release,
    output logic       ch_d_key_off,
    output logic       ch_e_key_on,
    output logic       ch_e_key_release,
    output logic       ch_e_key_off,
    output logic       cmd_error
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
    ,
    output logic [4:0] key_status
`endif
);

    localparam logic [7:0] DIV_LAST = 8'(SLOT_DIV - 1);

    logic [7:0]        div_cnt;
    logic              div_wrap;
    logic [2:0]        active_next;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] dispatch;
    logic [NUM_CH-1:0] on_p;
    logic [NUM_CH-1:0] rel_p;
    logic [NUM_CH-1:0] off_p;
    logic [7:0]        pending_ext;
    logic              cmd_good;
    logic              accept;

    assign div_wrap    = (div_cnt == DIV_LAST);
    assign active_next = next_slot(active);

    // Out-of-range channels are always ready so bad commands drain and flag an error.
    assign pending_ext = {{(8-NUM_CH){1'b0}}, pending};
    assign cmd_ready   = (cmd_ch >= SLOT_NOP) | ~pending_ext[cmd_ch];
    assign cmd_good    = (cmd_ch < 3'(NUM_CH)) && (cmd_key != 2'd0);
    assign accept      = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_cnt     <= 8'd0;
            active      <= SLOT_NOP;
            frame_start <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            div_cnt     <= div_wrap ? 8'd0 : div_cnt + 8'd1;
            frame_start <= div_wrap && (active_next == 3'd0);
            if (div_wrap) begin
                active <= active_next;
            end
            if (accept && !cmd_good) begin
                cmd_error <= 1'b1;
            end
        end
    end

    // Dispatch strobes fire on the edge that enters a channel's slot.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign wr_en[n]    = accept && cmd_good && (cmd_ch == 3'(n));
        assign dispatch[n] = div_wrap && (active_next == 3'(n));

        wts_key_pending_slot u_slot (
            .clk         (clk),
            .nreset      (nreset),
            .wr_en       (wr_en[n]),
            .wr_cmd      (key_cmd_t'(cmd_key)),
            .dispatch    (dispatch[n]),
            .pending     (pending[n]),
            .key_on      (on_p[n]),
            .key_release (rel_p[n]),
            .key_off     (off_p[n])
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
            ,
            .key_status  (key_status[n])
`endif
        );
    end

    assign ch_a_key_on      = on_p[0];
    assign ch_a_key_release = rel_p[0];
    assign ch_a_key_off     = off_p[0];
    assign ch_b_key_on      = on_p[1];
    assign ch_b_key_release = rel_p[1];
    assign ch_b_key_off     = off_p[1];
    assign ch_c_key_on      = on_p[2];
    assign ch_c_key_release = rel_p[2];
    assign ch_c_key_off     = off_p[2];
    assign ch_d_key_on      = on_p[3];
    assign ch_d_key_release = rel_p[3];
    assign ch_d_key_off     = off_p[3];
    assign ch_e_key_on      = on_p[4];
    assign ch_e_key_release = rel_p[4];
    assign ch_e_key_off     = off_p[4];

endmodule

// File: tb/tb_wts_key_scheduler.sv
// Scoreboard bench for wts_key_scheduler: one instance with SLOT_DIV=1 and one with SLOT_DIV=4.
// Also checks key_status when WTS_KEY_SCHEDULER_STATUS_EN is defined.
module tb_wts_key_scheduler;
    import wts_key_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       nreset    [2];
    logic       cmd_valid [2];
    logic [2:0] cmd_ch    [2];
    logic [1:0] cmd_key   [2];

    wire        ready_0, ready_1, fs_0, fs_1, err_0, err_1;
    wire [2:0]  act_0, act_1;
    wire [14:0] pl_0, pl_1;
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
    wire [4:0]  ks_0, ks_1;
    logic [4:0] model_status [2];
`endif

    always #5 clk = ~clk;

    wts_key_scheduler #(.SLOT_DIV(1)) dut_div1 (
        .clk(clk), .nreset(nreset[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(ready_0),
        .cmd_ch(cmd_ch[0]), .cmd_key(cmd_key[0]), .active(act_0), .frame_start(fs_0),
        .ch_a_key_on(pl_0[0]),  .ch_a_key_release(pl_0[1]),  .ch_a_key_off(pl_0[2]),
        .ch_b_key_on(pl_0[3]),  .ch_b_key_release(pl_0[4]),  .ch_b_key_off(pl_0[5]),
        .ch_c_key_on(pl_0[6]),  .ch_c_key_release(pl_0[7]),  .ch_c_key_off(pl_0[8]),
        .ch_d_key_on(pl_0[9]),  .ch_d_key_release(pl_0[10]), .ch_d_key_off(pl_0[11]),
        .ch_e_key_on(pl_0[12]), .ch_e_key_release(pl_0[13]), .ch_e_key_off(pl_0[14]),
        .cmd_error(err_0)
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
        , .key_status(ks_0)
`endif
    );

    wts_key_scheduler #(.SLOT_DIV(4)) dut_div4 (
        .clk(clk), .nreset(nreset[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(ready_1),
        .cmd_ch(cmd_ch[1]), .cmd_key(cmd_key[1]), .active(act_1), .frame_start(fs_1),
        .ch_a_key_on(pl_1[0]),  .ch_a_key_release(pl_1[1]),  .ch_a_key_off(pl_1[2]),
        .ch_b_key_on(pl_1[3]),  .ch_b_key_release(pl_1[4]),  .ch_b_key_off(pl_1[5]),
        .ch_c_key_on(pl_1[6]),  .ch_c_key_release(pl_1[7]),  .ch_c_key_off(pl_1[8]),
        .ch_d_key_on(pl_1[9]),  .ch_d_key_release(pl_1[10]), .ch_d_key_off(pl_1[11]),
        .ch_e_key_on(pl_1[12]), .ch_e_key_release(pl_1[13]), .ch_e_key_off(pl_1[14]),
        .cmd_error(err_1)
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
        , .key_status(ks_1)
`endif
    );

    typedef struct {
        int d;
        int ch;
        int key;
        int edge_k;
    } exp_t;

    exp_t sb [$];
    int   edge_k    [2] = '{0, 0};
    logic model_err [2];
    int   checks   = 0;
    int   failures = 0;

    function automatic int slot_div(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [2:0] get_active(input int d);
        return (d == 0) ? act_0 : act_1;
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? ready_0 : ready_1;
    endfunction

    function automatic logic get_fs(input int d);
        return (d == 0) ? fs_0 : fs_1;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err_0 : err_1;
    endfunction

    function automatic logic [14:0] get_pl(input int d);
        return (d == 0) ? pl_0 : pl_1;
    endfunction

    function automatic bit is_pending(input int d, input int ch);
        foreach (sb[i]) begin
            if (sb[i].d == d && sb[i].ch == ch) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Rising edges since reset release; edge k advances the slot when k is a multiple of SLOT_DIV.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            edge_k[d] <= nreset[d] ? edge_k[d] + 1 : 0;
        end
    end

    task automatic checkOutput(input string name, input int d, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, actual, expected, $time);
        end
    endtask

    task automatic monitorDut(input int d);
        int          k;
        int          dv;
        int          idx;
        logic [14:0] p;
        logic [2:0]  bits;
        k  = edge_k[d];
        dv = slot_div(d);
        p  = get_pl(d);
        if (!nreset[d]) begin
            checkOutput("reset_active", d, get_active(d), 5);
            checkOutput("reset_pulses", d, p, 0);
            checkOutput("reset_frame_start", d, get_fs(d), 0);
            checkOutput("reset_cmd_error", d, get_err(d), 0);
            return;
        end
        checkOutput("active", d, get_active(d), (5 + k / dv) % 6);
        checkOutput("frame_start", d, get_fs(d), (k % dv == 0 && (5 + k / dv) % 6 == 0) ? 1 : 0);
        checkOutput("cmd_error", d, get_err(d), model_err[d]);
        for (int ch = 0; ch < 5; ch++) begin
            bits = p[3*ch +: 3];
            if (bits != 3'b000) begin
                idx = -1;
                foreach (sb[i]) begin
                    if (idx < 0 && sb[i].d == d && sb[i].ch == ch) idx = i;
                end
                if (idx < 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_pulse dut%0d ch%0d: got pulses %b, expected none (edge %0d)", d, ch, bits, k);
                end else begin
                    checkOutput("pulse_kind", d, bits, 1 << (sb[idx].key - 1));
                    checkOutput("pulse_edge", d, k, sb[idx].edge_k);
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
                    if (sb[idx].key == 1) model_status[d][ch] = 1'b1;
                    if (sb[idx].key == 3) model_status[d][ch] = 1'b0;
`endif
                    sb.delete(idx);
                end
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].d == d && sb[i].edge_k < k) begin
                checks++;
                failures++;
                $display("[TB] FAIL missed_dispatch dut%0d ch%0d: got no pulse, expected key %0d at edge %0d", d, sb[i].ch, sb[i].key, sb[i].edge_k);
                sb.delete(i);
            end
        end
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
        checkOutput("key_status", d, (d == 0) ? ks_0 : ks_1, model_status[d]);
`endif
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitorDut(d);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idleBus(input int d);
        cmd_valid[d] = 1'b0;
        cmd_ch[d]    = 3'd0;
        cmd_key[d]   = 2'd0;
    endtask

    // Drives one offer; if the model says it is accepted, the expected dispatch is queued.
    task automatic applyStimulus(input int d, input int ch, input int key, output bit accepted);
        int ka;
        int kd;
        int dv;
        bit exp_ready;
        cmd_valid[d] = 1'b1;
        cmd_ch[d]    = 3'(ch);
        cmd_key[d]   = 2'(key);
        #1;
        exp_ready = (ch > 4) ? 1'b1 : !is_pending(d, ch);
        checkOutput("cmd_ready", d, get_ready(d), exp_ready);
        accepted = exp_ready;
        if (!accepted) return;
        if (ch > 4 || key == 0) begin
            model_err[d] = 1'b1;
            return;
        end
        dv = slot_div(d);
        ka = edge_k[d] + 1;
        kd = ka + 1;
        while (!(kd % dv == 0 && (5 + kd / dv) % 6 == ch)) kd++;
        sb.push_back('{d, ch, key, kd});
    endtask

    task automatic offerUntilAccepted(input int d, input int ch, input int key, input int max_tries);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < max_tries && !acc; t++) begin
            applyStimulus(d, ch, key, acc);
            if (!acc) tick();
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout dut%0d ch%0d: got no acceptance, expected within %0d clocks", d, ch, max_tries);
        end
        tick();
        idleBus(d);
    endtask

    task automatic waitActive(input int d, input int v);
        int n;
        n = 0;
        while (get_active(d) != 3'(v) && n < 100) begin
            tick();
            n++;
        end
        if (get_active(d) != 3'(v)) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_active dut%0d: got %0d, expected %0d within 100 clocks", d, get_active(d), v);
        end
    endtask

    task automatic resetDut(input int d);
        nreset[d] = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].d == d) sb.delete(i);
        end
        model_err[d] = 1'b0;
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
        model_status[d] = 5'd0;
`endif
        idleBus(d);
        repeat (2) tick();
        nreset[d] = 1'b1;
    endtask

    task automatic randomPhase(input int d, input int n);
        int ch;
        int key;
        bit acc;
        for (int i = 0; i < n; i++) begin
            ch  = ($urandom_range(0, 9) == 0) ? 5 + $urandom_range(0, 2) : $urandom_range(0, 4);
            key = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            applyStimulus(d, ch, key, acc);
            tick();
            if ($urandom_range(0, 1) == 1) begin
                idleBus(d);
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        idleBus(d);
        repeat (6 * slot_div(d) + 2) tick();
    endtask

    initial begin
        bit acc;
        for (int d = 0; d < 2; d++) begin
            nreset[d]    = 1'b0;
            model_err[d] = 1'b0;
`ifdef WTS_KEY_SCHEDULER_STATUS_EN
            model_status[d] = 5'd0;
`endif
            idleBus(d);
        end
        resetDut(0);
        resetDut(1);

        $display("[TB] idle slot sequencing");
        repeat (50) tick();

        $display("[TB] key_on ch A offered in slot 3");
        waitActive(0, 3);
        applyStimulus(0, 0, int'(KEY_ON), acc);
        tick();
        idleBus(0);
        repeat (8) tick();

        $display("[TB] back-to-back key_on / key_off on ch C");
        offerUntilAccepted(0, 2, int'(KEY_ON), 20);
        offerUntilAccepted(0, 2, int'(KEY_OFF), 20);
        repeat (14) tick();

        $display("[TB] ch B accepted on the edge entering slot 1");
        waitActive(0, 0);
        applyStimulus(0, 1, int'(KEY_RELEASE), acc);
        tick();
        idleBus(0);
        repeat (10) tick();

        $display("[TB] invalid channel and empty key");
        applyStimulus(0, 6, int'(KEY_ON), acc);
        tick();
        applyStimulus(0, 2, int'(KEY_NONE), acc);
        tick();
        idleBus(0);
        repeat (10) tick();

        $display("[TB] random traffic, SLOT_DIV=1");
        randomPhase(0, 80);
        resetDut(0);
        repeat (12) tick();

        $display("[TB] SLOT_DIV=4 slot hold and ch E key_release");
        repeat (30) tick();
        waitActive(1, 1);
        applyStimulus(1, 4, int'(KEY_RELEASE), acc);
        tick();
        idleBus(1);
        repeat (30) tick();

        $display("[TB] reset while ch D pending");
        waitActive(1, 4);
        applyStimulus(1, 3, int'(KEY_ON), acc);
        tick();
        idleBus(1);
        repeat (3) tick();
        resetDut(1);
        repeat (40) tick();

        $display("[TB] random traffic, SLOT_DIV=4");
        randomPhase(1, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 1 ms");
        $fatal(1);
    end

endmodule
